perceptron_trainer: RTL

- Online training engine that produces the weight and bias set consumed by the on-chip perceptron classifier.
- Accepts labelled binary samples over a valid/ready handshake and evaluates the current model by serial accumulation.
- Reports the prediction, then applies the perceptron learning rule on a misprediction.
- Exports the full weight vector and bias for the classifier, plus error and sample statistics.

---
 rtl/perceptron_trainer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: serial dot product, one-cycle prediction strobe, saturating update rule.
// Optional convergence freeze is compiled in by defining PERCEPTRON_TRAINER_CONVERGE_EN.
module perceptron_trainer #(
   parameter int N_IN      = 8,
   parameter int W_WIDTH   = 6,
   parameter int CNT_WIDTH = 8,
   parameter int CONV_RUN  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    train_en,
   input  logic                    clr_stats,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   input  logic [N_IN-1:0]         sample_bits,
   input  logic                    target,
   output logic                    pred_valid,
   output logic                    pred,
   output logic                    mispredict,
   output logic [N_IN*W_WIDTH-1:0] weights,
   output logic [W_WIDTH-1:0]      bias,
   output logic [CNT_WIDTH-1:0]    err_count,
   output logic [CNT_WIDTH-1:0]    sample_count,
   output logic                    converged
);
   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int ACC_W = W_WIDTH + $clog2(N_IN + 1) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
   localparam logic signed [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
   localparam logic signed [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};
   localparam logic signed [W_WIDTH-1:0] ONE   = W_WIDTH'(1);

   if (N_IN < 2 || W_WIDTH < 2 || CNT_WIDTH < 1 || CONV_RUN < 1) begin : g_param_check
      $error("perceptron_trainer: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, UPDATE} state_t;

   state_t                    state;
   logic [N_IN-1:0]           x_reg;
   logic                      tgt_reg;
   logic [IDX_W-1:0]          idx;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_next;
   logic signed [ACC_W-1:0]   score;
   logic signed [W_WIDTH-1:0] w [N_IN];
   logic signed [W_WIDTH-1:0] bias_reg;
   logic                      frozen;

   // One +/-1 step that clamps at the signed range instead of wrapping.
   function automatic logic signed [W_WIDTH-1:0] sat_step(input logic signed [W_WIDTH-1:0] v,
                                                          input logic en, input logic up);
      if (!en) return v;
      if (up) return (v == W_MAX) ? v : v + ONE;
      return (v == W_MIN) ? v : v - ONE;
   endfunction

   always_comb begin
      acc_next = acc;
      if (x_reg[idx]) acc_next = acc + ACC_W'(w[idx]);
      score = acc_next + ACC_W'(bias_reg);
   end

   assign sample_ready = (state == IDLE);
   assign bias         = bias_reg;

   for (genvar g = 0; g < N_IN; g++) begin : g_flat
      assign weights[g*W_WIDTH +: W_WIDTH] = w[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         x_reg        <= '0;
         tgt_reg      <= 1'b0;
         idx          <= '0;
         acc          <= '0;
         bias_reg     <= '0;
         pred         <= 1'b0;
         pred_valid   <= 1'b0;
         mispredict   <= 1'b0;
         err_count    <= '0;
         sample_count <= '0;
         for (int i = 0; i < N_IN; i++) w[i] <= '0;
      end else begin
         pred_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (sample_valid) begin
                  x_reg   <= sample_bits;
                  tgt_reg <= target;
                  acc     <= '0;
                  idx     <= '0;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= idx + IDX_W'(1);
               // The final term is folded in here so the decision is registered on entry to DECIDE.
               if (idx == LAST_IDX) begin
                  pred       <= ~score[ACC_W-1];
                  mispredict <= ~score[ACC_W-1] ^ tgt_reg;
                  pred_valid <= 1'b1;
                  state      <= DECIDE;
               end
            end
            DECIDE: state <= UPDATE;
            UPDATE: begin
               if (train_en && mispredict && !frozen) begin
                  for (int i = 0; i < N_IN; i++) w[i] <= sat_step(w[i], x_reg[i], tgt_reg);
                  bias_reg <= sat_step(bias_reg, 1'b1, tgt_reg);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (clr_stats) begin
            err_count    <= '0;
            sample_count <= '0;
         end else if (state == DECIDE) begin
            if (sample_count != '1) sample_count <= sample_count + CNT_WIDTH'(1);
            if (mispredict && err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
         end
      end
   end

`ifdef PERCEPTRON_TRAINER_CONVERGE_EN
   localparam int RUN_W = $clog2(CONV_RUN + 1);

   logic [RUN_W-1:0] run;
   logic             conv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run  <= '0;
         conv <= 1'b0;
      end else if (clr_stats) begin
         run  <= '0;
         conv <= 1'b0;
      end else if (state == DECIDE) begin
         if (mispredict) run <= '0;
         else if (run != RUN_W'(CONV_RUN)) run <= run + RUN_W'(1);
         if (!mispredict && run == RUN_W'(CONV_RUN - 1)) conv <= 1'b1;
      end
   end

   assign converged = conv;
   assign frozen    = conv;
`else
   assign converged = 1'b0;
   assign frozen    = 1'b0;
`endif

endmodule
